tt_um_serial_adder: RTL
=======================

# tt_um_serial_adder

Bit-serial, parametrised add/subtract unit for a Tiny Tapeout tile. It is the sequential successor to the single-bit combinational half adder. Two WIDTH-bit operands are loaded over the dedicated input bus, and one full-adder cell processes one bit per clock, LSB first. The result and the carry/overflow flags are latched on the tile outputs. It sits directly behind the standard TT top-level pinout.

## Interface
- WIDTH, 8: operand/result width in bits; legal range 1..8.
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- ena  input  1  always 1 when powered; unused.
- ui_in  input  8  operand data bus; bits [WIDTH-1:0] used.
- uio_in  input  8  control: [0] load_a, [1] load_b, [2] start, [3] sub (1 = A−B, 0 = A+B); [7:4] unused.
- uo_out  output  8  result register; bits [7:WIDTH] always 0.
- uio_out  output  8  [4] busy, [5] done, [6] carry, [7] overflow; [3:0] always 0.
- uio_oe  output  8  constant 8'hF0.

## Operation
- Registers:
  - op_a, op_b: WIDTH-bit shift registers.
  - sum_sh: WIDTH-bit shift register.
  - carry: 1 bit.
  - bit count: ceil(log2(WIDTH+1)) bits.
  - mode latch.
  - result, flag_c, flag_v: output registers.
- FSM states are IDLE, RUN and DONE.
- IDLE or DONE:
  - load_a=1 captures ui_in[WIDTH-1:0] into op_a. load_b=1 does the same into op_b. Both may be asserted in the same cycle.
  - start=1 with no load asserted latches sub and sets carry to sub. If sub=1, op_b is inverted in place (two's complement: ~B + 1). Count is cleared and the FSM goes to RUN.
  - start asserted in the same cycle as any load: the start is ignored and the loads are performed.
  - Any load in DONE clears done and returns the FSM to IDLE. result and the flags are held.
- RUN, each cycle:
  - s = a0 ^ b0 ^ carry. carry ← majority(a0, b0, carry).
  - s is shifted into the MSB of sum_sh. op_a and op_b shift right.
  - count increments.
  - On the cycle that processes bit WIDTH-1: flag_v ← (carry-in to MSB) ^ (carry-out of MSB). flag_c ← carry-out. result ← final sum. FSM goes to DONE.
  - load_a, load_b and start are ignored throughout RUN.
- DONE: done=1, busy=0. start (with no load) begins a new operation on the current op_a/op_b contents. This makes back-to-back repeat operations possible.
- Subtract: flag_c=1 means no borrow (A ≥ B unsigned). flag_v is signed overflow.
- WIDTH=1 degenerates to a registered full adder: RUN lasts one cycle.

## Timing
- Reset (async assert, sync release):
  - State IDLE; all registers 0.
  - uo_out=0, uio_out=0, uio_oe=8'hF0.
- Rising edge E0 samples start → busy=1 from E0.
- Edges E1..EWIDTH process bits 0..WIDTH-1. Edge EWIDTH writes result and flags and enters DONE.
- Latency: done=1 and the new uo_out are visible WIDTH+1 edges after the sampled start edge.
- uo_out and the flags hold their previous values during RUN. They change only on the DONE-entry edge.
- busy and done are never both 1. Both are 0 in IDLE.
- rst_n low mid-RUN aborts immediately to reset values. No partial result is written.

## Structure
- Shared package tt_serial_adder_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - control bit-index localparams (LOAD_A=0, LOAD_B=1, START=2, SUB=3);
  - status bit-index localparams (BUSY=4, DONE=5, CARRY=6, OVF=7);
  - UIO_OE_MASK = 8'hF0.
- One sub-module, fa_cell: combinational full adder built from two half adders plus an OR. Ports: a, b, cin, s, cout.
- The top instantiates one fa_cell, the FSM and the datapath shift registers.

## Test plan
- WIDTH=8, load A=8'h5A, B=8'h3C, start add → after 9 edges: uo_out=8'h96, carry=0, overflow=1, done=1, busy low.
- WIDTH=8, A=8'hFF, B=8'h01, add → uo_out=8'h00, carry=1, overflow=0. Immediately start sub on the reloaded A=8'h10, B=8'h20 → uo_out=8'hF0, carry=0, overflow=0.
- Start pulsed again 3 cycles into RUN, and load_a with ui_in=8'hAA also mid-RUN → both ignored. The result matches the original operands, and op_a is unchanged for the next start.
- load_a and start in the same cycle → FSM stays IDLE, busy=0, op_a captured. A following start alone runs normally.
- rst_n pulsed low at cycle 4 of RUN → all outputs 0 within the same cycle, uio_oe=8'hF0, state IDLE. The previous result is not restored.
- WIDTH=4, A=4'h7, B=4'h1, add → result visible after 5 edges: uo_out=8'h08, overflow=1, carry=0, uo_out[7:4]=0.

Source files
------------

// File: rtl/tt_serial_adder_pkg.sv
// Shared types and bit positions for the bit-serial add/subtract tile.
package tt_serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int LOAD_A = 0;
  localparam int LOAD_B = 1;
  localparam int START  = 2;
  localparam int SUB    = 3;

  localparam int BUSY  = 4;
  localparam int DONE  = 5;
  localparam int CARRY = 6;
  localparam int OVF   = 7;

  localparam logic [7:0] UIO_OE_MASK = 8'hF0;

  typedef struct packed {
    logic load_a;
    logic load_b;
    logic start;
    logic sub;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [7:0] uio);
    ctrl_t c;
    c.load_a = uio[LOAD_A];
    c.load_b = uio[LOAD_B];
    c.start  = uio[START];
    c.sub    = uio[SUB];
    return c;
  endfunction

endpackage

// File: rtl/tt_um_serial_adder_fa_cell.sv
// Combinational full adder assembled from two half adders and an OR.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic hs_ab;
  logic hc_ab;
  logic hc_cin;

  assign hs_ab  = a ^ b;
  assign hc_ab  = a & b;
  assign s      = hs_ab ^ cin;
  assign hc_cin = hs_ab & cin;
  assign cout   = hc_ab | hc_cin;

endmodule

// File: rtl/tt_um_serial_adder.sv
// Bit-serial WIDTH-bit add/subtract behind the Tiny Tapeout pinout, one bit per clock, LSB first.
// state   | meaning
// ST_IDLE | accepting loads/start, outputs hold last result
// ST_RUN  | shifting operands through the full-adder cell
// ST_DONE | result valid, done=1; loads or start still accepted
module tt_um_serial_adder
  import tt_serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q;
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic [WIDTH-1:0] sum_sh_q;
  logic [WIDTH-1:0] result_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             mode_sub_q;
  logic             flag_c_q;
  logic             flag_v_q;
  logic             busy_q;
  logic             done_q;

  ctrl_t            ctl_d;
  logic             any_load_d;
  logic             s_d;
  logic             cout_d;
  logic             last_bit_d;
  logic [WIDTH:0]   sum_cat_d;
  logic [WIDTH:0]   a_cat_d;
  logic [WIDTH:0]   b_cat_d;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] op_a_d;
  logic [WIDTH-1:0] op_b_d;
  logic             unused_d;

  assign ctl_d      = decode_ctrl(uio_in);
  assign any_load_d = ctl_d.load_a | ctl_d.load_b;
  assign last_bit_d = (cnt_q == CW'(WIDTH - 1));

  fa_cell u_fa (
    .a    (op_a_q[0]),
    .b    (op_b_q[0]),
    .cin  (carry_q),
    .s    (s_d),
    .cout (cout_d)
  );

  // Operands rotate rather than shift so a repeat start sees them intact after WIDTH cycles.
  assign sum_cat_d = {s_d, sum_sh_q};
  assign a_cat_d   = {op_a_q[0], op_a_q};
  assign b_cat_d   = {op_b_q[0], op_b_q};
  assign sum_d     = sum_cat_d[WIDTH:1];
  assign op_a_d    = a_cat_d[WIDTH:1];
  assign op_b_d    = b_cat_d[WIDTH:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_a_q     <= '0;
      op_b_q     <= '0;
      sum_sh_q   <= '0;
      result_q   <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      mode_sub_q <= 1'b0;
      flag_c_q   <= 1'b0;
      flag_v_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (any_load_d) begin
            if (ctl_d.load_a) op_a_q <= ui_in[WIDTH-1:0];
            if (ctl_d.load_b) op_b_q <= ui_in[WIDTH-1:0];
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end else if (ctl_d.start) begin
            mode_sub_q <= ctl_d.sub;
            carry_q    <= ctl_d.sub;
            if (ctl_d.sub) op_b_q <= ~op_b_q;
            cnt_q   <= '0;
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          carry_q  <= cout_d;
          sum_sh_q <= sum_d;
          op_a_q   <= op_a_d;
          op_b_q   <= op_b_d;
          cnt_q    <= cnt_q + CW'(1);
          if (last_bit_d) begin
            result_q <= sum_d;
            flag_c_q <= cout_d;
            flag_v_q <= carry_q ^ cout_d;
            state_q  <= ST_DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    uo_out               = '0;
    uo_out[WIDTH-1:0]    = result_q;
    uio_out              = '0;
    uio_out[BUSY]        = busy_q;
    uio_out[DONE]        = done_q;
    uio_out[CARRY]       = flag_c_q;
    uio_out[OVF]         = flag_v_q;
  end

  assign uio_oe   = UIO_OE_MASK;
  assign unused_d = ^{ena, uio_in[7:4], ui_in, mode_sub_q};

endmodule
